// File: rtl/serial_twos_comp.sv
// serial_twos_comp
// ----------------
// LSB-first bit-serial two's complement unit. Each of LANES parallel lanes
// carries an independent WORD_W-bit serial word, and all lanes share the same
// framing. Each word is either negated or passed through, as selected by
// in_negate on its first bit. One register stage sits between input and output.
//
// Negation uses the classic serial rule: copy bits up to and including the
// first 1, then invert every later bit. A per-lane "seen a one" state machine
// (Q0/Q1) tracks which of those two phases the lane is in.
//
// Optional feature macro: SERIAL_TWOS_COMP_OVF_EN
//   defined   -> per-lane overflow detection (negating -2^(WORD_W-1))
//   undefined -> ovf tied to zero, detection logic absent
//
// Ports
//   clk        rising-edge clock
//   n_reset    asynchronous active-low reset
//   sync_clr   synchronous abort; discards the word in progress
//   in_valid   input bits valid this cycle
//   in_data    one serial bit per lane, LSB first
//   in_negate  word mode (1 negate, 0 pass), sampled on the first bit only
//   out_valid  output bits valid
//   out_data   result bits, LSB first; holds its value while out_valid is low
//   out_last   marks the final (MSB) bit of an output word
//   ovf        per-lane overflow flag, only ever high together with out_last

module serial_twos_comp #(
    parameter int WORD_W = 8,
    parameter int LANES  = 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             sync_clr,
    input  logic             in_valid,
    input  logic [LANES-1:0] in_data,
    input  logic             in_negate,
    output logic             out_valid,
    output logic [LANES-1:0] out_data,
    output logic             out_last,
    output logic [LANES-1:0] ovf
);

    localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

    typedef enum logic {
        Q0 = 1'b0,
        Q1 = 1'b1
    } seen_t;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             neg;
    logic             neg_next;
    seen_t            q      [LANES];
    seen_t            q_next [LANES];

    logic             first_bit;
    logic             last_bit;
    logic             eff_neg;
    logic             take;
    logic [LANES-1:0] res_bit;

    // sync_clr drops a bit presented in the same cycle, so it never reaches the output
    assign take = in_valid & ~sync_clr;

    // Bit position, word mode and the effective mode for the current bit.
    // On the first bit the stored mode is stale, so in_negate is used directly.
    always_comb begin
        first_bit = (cnt == '0);
        last_bit  = (cnt == LAST_CNT);
        eff_neg   = first_bit ? in_negate : neg;
        cnt_next  = cnt;
        neg_next  = neg;
        if (sync_clr) begin
            cnt_next = '0;
        end else if (in_valid) begin
            cnt_next = last_bit ? '0 : cnt + CNT_W'(1);
            if (first_bit) begin
                neg_next = in_negate;
            end
        end
    end

    // Per-lane seen-one machine and result bit. The lane state returns to Q0
    // after the last bit, so a back-to-back word starts clean.
    always_comb begin
        res_bit = '0;
        for (int i = 0; i < LANES; i++) begin
            q_next[i] = q[i];
            res_bit[i] = (eff_neg && (q[i] == Q1)) ? ~in_data[i] : in_data[i];
            if (sync_clr) begin
                q_next[i] = Q0;
            end else if (in_valid) begin
                if (last_bit) begin
                    q_next[i] = Q0;
                end else if (q[i] == Q0) begin
                    q_next[i] = in_data[i] ? Q1 : Q0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt <= '0;
            neg <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                q[i] <= Q0;
            end
        end else begin
            cnt <= cnt_next;
            neg <= neg_next;
            for (int i = 0; i < LANES; i++) begin
                q[i] <= q_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= take;
            out_last  <= take & last_bit;
            if (take) begin
                out_data <= res_bit;
            end
        end
    end

`ifdef SERIAL_TWOS_COMP_OVF_EN
    logic [LANES-1:0] ovf_bit;

    // Only -2^(WORD_W-1) overflows when negated: the lane is still in Q0 when
    // the MSB arrives, and that MSB is 1. Its output is the unchanged input.
    always_comb begin
        ovf_bit = '0;
        for (int i = 0; i < LANES; i++) begin
            ovf_bit[i] = eff_neg && last_bit && (q[i] == Q0) && in_data[i];
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ovf <= '0;
        end else begin
            ovf <= take ? ovf_bit : '0;
        end
    end
`else
    assign ovf = '0;
`endif

endmodule

// File: tb/tb_serial_twos_comp.sv
// tb_serial_twos_comp
// -------------------
// Directed testbench for serial_twos_comp. One instance uses WORD_W=8 and
// LANES=1, and a second uses LANES=2. Expected words are computed by hand.
// Expected ovf values depend on whether SERIAL_TWOS_COMP_OVF_EN is defined.

module tb_serial_twos_comp;

`ifdef SERIAL_TWOS_COMP_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_reset;
    logic       sync_clr;
    logic       in_valid;
    logic [0:0] in_data;
    logic       in_negate;
    logic       out_valid;
    logic [0:0] out_data;
    logic       out_last;
    logic [0:0] ovf;

    logic       in_valid2;
    logic [1:0] in_data2;
    logic       in_negate2;
    logic       out_valid2;
    logic [1:0] out_data2;
    logic       out_last2;
    logic [1:0] ovf2;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    serial_twos_comp #(.WORD_W(8), .LANES(1)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .sync_clr  (sync_clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_negate (in_negate),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    serial_twos_comp #(.WORD_W(8), .LANES(2)) dut2 (
        .clk       (clk),
        .n_reset   (n_reset),
        .sync_clr  (1'b0),
        .in_valid  (in_valid2),
        .in_data   (in_data2),
        .in_negate (in_negate2),
        .out_valid (out_valid2),
        .out_data  (out_data2),
        .out_last  (out_last2),
        .ovf       (ovf2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Send one 8-bit word on the single-lane instance, with 'gap' idle cycles
    // between bits. in_negate is inverted after the first bit to show that only
    // the first bit's mode counts.
    task automatic applyStimulus(input string tag, input logic [7:0] word,
                                 input logic neg, input int gap,
                                 input logic [7:0] exp_word, input logic exp_ovf);
        logic [7:0] got;
        got = '0;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_data   = word[i];
            in_negate = (i == 0) ? neg : ~neg;
            @(posedge clk);
            #1;
            checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_last"}, 32'(out_last), 32'(i == 7));
            checkOutput({tag, "_ovf"}, 32'(ovf), (i == 7) ? 32'(exp_ovf & OVF_EN) : 32'd0);
            got[i]   = out_data[0];
            in_valid = 1'b0;
            in_data  = '0;
            if (i < 7) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                    checkOutput({tag, "_gapvalid"}, 32'(out_valid), 32'd0);
                    checkOutput({tag, "_gaphold"}, 32'(out_data), 32'(got[i]));
                end
            end
        end
        checkOutput({tag, "_word"}, 32'(got), 32'(exp_word));
    endtask

    initial begin
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] got0;
        logic [7:0] got1;

        n_reset    = 1'b0;
        sync_clr   = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_negate  = 1'b0;
        in_valid2  = 1'b0;
        in_data2   = '0;
        in_negate2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_last", 32'(out_last), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst2_valid", 32'(out_valid2), 32'd0);
        checkOutput("rst2_ovf", 32'(ovf2), 32'd0);

        n_reset = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("neg05", 8'h05, 1'b1, 0, 8'hFB, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("idle_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_hold", 32'(out_data), 32'd1);

        applyStimulus("neg80", 8'h80, 1'b1, 0, 8'h80, 1'b1);
        applyStimulus("neg00", 8'h00, 1'b1, 0, 8'h00, 1'b0);
        applyStimulus("pass5A", 8'h5A, 1'b0, 0, 8'h5A, 1'b0);
        applyStimulus("neg5A", 8'h5A, 1'b1, 0, 8'hA6, 1'b0);
        @(posedge clk);
        #1;

        applyStimulus("gap0C", 8'h0C, 1'b1, 3, 8'hF4, 1'b0);
        @(posedge clk);
        #1;

        // Abort a word at bit 4 with sync_clr; the next word must frame from bit 0.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_data   = 1'b1;
            in_negate = 1'b1;
            @(posedge clk);
            #1;
        end
        sync_clr = 1'b1;
        in_data  = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("clr_valid", 32'(out_valid), 32'd0);
        checkOutput("clr_last", 32'(out_last), 32'd0);
        sync_clr = 1'b0;
        in_valid = 1'b0;
        applyStimulus("clr01", 8'h01, 1'b1, 0, 8'hFF, 1'b0);

        // Asynchronous reset in the middle of bit 4 clears the outputs at once.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            in_data   = (i == 0) ? 1'b1 : 1'b0;
            in_negate = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("rstmid_pre", 32'(out_data), 32'd1);
        in_data = 1'b0;
        #2;
        n_reset = 1'b0;
        #1;
        checkOutput("rstmid_valid", 32'(out_valid), 32'd0);
        checkOutput("rstmid_data", 32'(out_data), 32'd0);
        checkOutput("rstmid_last", 32'(out_last), 32'd0);
        checkOutput("rstmid_ovf", 32'(ovf), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("rst01", 8'h01, 1'b1, 0, 8'hFF, 1'b0);

        // Two lanes: lane0 = 0x03, lane1 = 0x80, both negated.
        w0   = 8'h03;
        w1   = 8'h80;
        got0 = '0;
        got1 = '0;
        for (int i = 0; i < 8; i++) begin
            in_valid2  = 1'b1;
            in_data2   = {w1[i], w0[i]};
            in_negate2 = (i == 0);
            @(posedge clk);
            #1;
            got0[i] = out_data2[0];
            got1[i] = out_data2[1];
            checkOutput("dual_last", 32'(out_last2), 32'(i == 7));
            checkOutput("dual_ovf", 32'(ovf2), (i == 7) ? 32'({OVF_EN, 1'b0}) : 32'd0);
        end
        in_valid2 = 1'b0;
        checkOutput("dual_lane0", 32'(got0), 32'h0000_00FD);
        checkOutput("dual_lane1", 32'(got1), 32'h0000_0080);
        @(posedge clk);
        #1;
        checkOutput("dual_idle", 32'(out_valid2), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
